// File: rtl/pattern_sequencer_pkg.sv
// Shared types and helpers for the video pattern sequencer.
// Holds the mode encoding, the debounce counter width and the select wrap rule.
package pattern_seq_pkg;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } seq_state_e;

    localparam int DEBOUNCE_W = 16;

    // Advance a pattern index, wrapping at the last pattern so no index >= num_patterns appears.
    function automatic int unsigned next_sel(input int unsigned sel, input int unsigned num_patterns);
        return (sel == num_patterns - 1) ? 32'd0 : sel + 32'd1;
    endfunction

endpackage

// File: rtl/pattern_sequencer_button_conditioner.sv
// Button conditioner: 2-flop synchronizer, optional debouncer, rising-edge detector.
// Define PATTERN_SEQ_DEBOUNCE_EN to insert a 2**16-cycle stability debouncer.
module button_conditioner
    import pattern_seq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    logic [1:0] r_sync;
    logic       w_sync;
    logic       w_level;
    logic       r_prev;
    logic       r_press;

    // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    assign w_sync = r_sync[1];

`ifdef PATTERN_SEQ_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] r_db_cnt;
    logic                  r_db_level;

    // The level follows the input only after it has differed for a full counter wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (w_sync == r_db_level) begin
            r_db_cnt <= '0;
        end else if (&r_db_cnt) begin
            r_db_cnt   <= '0;
            r_db_level <= w_sync;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = w_sync;
`endif

    // Registered edge detect: press event lands 3 cycles after the pin rises.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_press <= w_level & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/pattern_sequencer.sv
// Video test-pattern sequencer: advances the pattern select only at vblank start,
// automatically every FRAMES_PER_PATTERN frames or on a queued manual request.
// Optional macro PATTERN_SEQ_DEBOUNCE_EN enables button debouncing.
module pattern_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS       = 4,
    parameter int unsigned SEL_W              = 2,
    parameter int unsigned FRAMES_PER_PATTERN = 60,
    parameter int unsigned FCNT_W             = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vblank,
    input  logic              i_btn_next,
    input  logic              i_btn_mode,
    output logic [SEL_W-1:0]  o_pattern_sel,
    output logic              o_auto,
    output logic              o_frame_tick,
    output logic              o_pending,
    output logic [FCNT_W-1:0] o_frame_count
);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_PATTERN - 1);

    seq_state_e        r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_sel, w_sel_nxt, w_sel_adv;
    logic              r_pending, w_pending_nxt;
    logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
    logic              r_vblank_d;
    logic              r_frame_tick;
    logic              w_next_press;
    logic              w_mode_press;

    button_conditioner u_btn_next (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_next),
        .o_press (w_next_press)
    );

    button_conditioner u_btn_mode (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_mode),
        .o_press (w_mode_press)
    );

    // vblank comes from the same clock domain, so no synchronizer is needed here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vblank_d   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vblank_d   <= i_vblank;
            r_frame_tick <= i_vblank & ~r_vblank_d;
        end
    end

    assign w_sel_adv = SEL_W'(next_sel(32'(r_sel), NUM_PATTERNS));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_pending_nxt = r_pending;
        w_fcnt_nxt    = r_fcnt;

        if (w_mode_press) begin
            // Mode change wins over a coincident tick and discards any queued request.
            w_state_nxt   = (r_state == ST_AUTO) ? ST_MANUAL : ST_AUTO;
            w_fcnt_nxt    = '0;
            w_pending_nxt = 1'b0;
        end else begin
            if (r_frame_tick) begin
                if (r_state == ST_AUTO) begin
                    if (r_pending || (r_fcnt == FCNT_LAST)) begin
                        w_sel_nxt     = w_sel_adv;
                        w_fcnt_nxt    = '0;
                        w_pending_nxt = 1'b0;
                    end else begin
                        w_fcnt_nxt = r_fcnt + 1'b1;
                    end
                end else begin
                    if (r_pending) begin
                        w_sel_nxt     = w_sel_adv;
                        w_pending_nxt = 1'b0;
                    end
                    if (!(&r_fcnt)) begin
                        w_fcnt_nxt = r_fcnt + 1'b1;
                    end
                end
            end
            // A press coincident with a tick is queued for the following tick.
            if (w_next_press) begin
                w_pending_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_AUTO;
            r_sel     <= '0;
            r_pending <= 1'b0;
            r_fcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_pending <= w_pending_nxt;
            r_fcnt    <= w_fcnt_nxt;
        end
    end

    assign o_pattern_sel = r_sel;
    assign o_auto        = (r_state == ST_AUTO);
    assign o_frame_tick  = r_frame_tick;
    assign o_pending     = r_pending;
    assign o_frame_count = r_fcnt;

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Controller that selects which video test pattern the pattern datapath displays. It sits beside the video sync generator and consumes its blanking outputs. Pattern changes are applied only at the start of vertical blank, so a frame never mixes two patterns. Patterns advance automatically every N frames or manually from a user button, and a second button toggles between auto and manual mode.

Parameters:
NUM_PATTERNS, 4, number of selectable patterns; legal range 2..2**SEL_W.
SEL_W, 2, width of pattern select.
FRAMES_PER_PATTERN, 60, frames each pattern is held in AUTO mode; must be at least 1.
FCNT_W, 8, frame counter width; must satisfy 2**FCNT_W > FRAMES_PER_PATTERN.

Ports:
i_clk  in  1  pixel clock, same clock as the sync generator.
i_rst  in  1  asynchronous, active-high reset.
i_vblank  in  1  vertical blank from the sync generator.
i_btn_next  in  1  asynchronous button input; request the next pattern.
i_btn_mode  in  1  asynchronous button input; toggle AUTO/MANUAL mode.
o_pattern_sel  out  SEL_W  registered pattern index; the datapath muxes on this.
o_auto  out  1  1 = AUTO mode, 0 = MANUAL mode.
o_frame_tick  out  1  one-cycle pulse on the rising edge of i_vblank.
o_pending  out  1  a manual advance is queued for the next frame tick.
o_frame_count  out  FCNT_W  frames elapsed on the current pattern.

Behaviour:
- Reset (async assert; deassert sampled on i_clk):
  - o_pattern_sel=0, o_auto=1, o_frame_tick=0, o_pending=0, o_frame_count=0.
  - Synchronizer and edge-detect flops are cleared to 0.
- Frame tick:
  - vblank_d is a one-cycle delayed copy of i_vblank.
  - o_frame_tick = i_vblank & ~vblank_d, registered, so it appears 1 cycle after i_vblank rises.
  - All pattern_sel updates happen only in the cycle o_frame_tick is high.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector, giving one single-cycle press event.
  - Latency from pin to press event: 3 cycles.
- States: AUTO and MANUAL. A mode press toggles the state on the next cycle. This does not wait for a frame tick.
- On entering either state, o_frame_count clears to 0 and o_pending clears.
- AUTO mode:
  - On each tick, o_frame_count increments.
  - When o_frame_count == FRAMES_PER_PATTERN-1 at a tick, o_pattern_sel advances and o_frame_count returns to 0.
  - A next press in AUTO sets o_pending. At the next tick this forces an advance and clears o_frame_count, whatever its value.
- MANUAL mode:
  - A next press sets o_pending.
  - At the tick, if o_pending=1, o_pattern_sel advances and o_pending clears.
  - o_frame_count keeps counting and saturates at 2**FCNT_W-1.
- Wrap-around: the advance is sel = (sel == NUM_PATTERNS-1) ? 0 : sel+1. No value >= NUM_PATTERNS is ever output.
- Simultaneous events:
  - A next press in the same cycle as a tick is not consumed by that tick. It sets o_pending, which is applied at the following tick.
  - A mode press in the same cycle as a tick has priority. The mode toggles, counters clear, and no advance occurs on that tick.
  - Multiple next presses within one frame queue only one advance; o_pending is a flag, not a count.
- Reset mid-frame returns to pattern 0 in AUTO mode immediately. The first tick after reset counts as frame 1.

Optional Feature:
PATTERN_SEQ_DEBOUNCE_EN:
- When defined, each synchronized button feeds a debouncer before the edge detector.
- The debouncer output changes only after the input has been stable for 2**16 consecutive cycles. It uses a 16-bit counter per button, cleared on any input change.
- Press latency becomes 3+65536 cycles.
- When not defined, there is no debouncer and the latency is 3 cycles, as described above.

Decomposition:
- Shared package pattern_seq_pkg holds:
  - the state encoding: ST_AUTO=1'b1, ST_MANUAL=1'b0;
  - the DEBOUNCE_W=16 constant;
  - a function next_sel(sel, NUM_PATTERNS) implementing the wrap rule.
- One sub-module, button_conditioner, is instantiated twice. It contains the synchronizer, the optional debouncer and the edge detector, and outputs a single-cycle press pulse.

Test Plan:
- Reset with FRAMES_PER_PATTERN=3 -> after reset: sel=0, o_auto=1. Drive 3 vblank rising edges -> sel=1 at the 3rd tick, frame_count back to 0.
- 12 ticks in AUTO, NUM_PATTERNS=4, FRAMES_PER_PATTERN=3 -> sel sequence 1,2,3,0; it never reaches 4.
- Press mode, then 2 next presses mid-frame -> o_auto=0, o_pending=1. Next tick -> sel +1 only (not +2), o_pending=0.
- Next press event in the same cycle as o_frame_tick (MANUAL mode) -> sel unchanged on that tick, o_pending=1; sel advances on the following tick.
- Mode press coincident with a tick in AUTO at frame_count=2 -> o_auto=0, frame_count=0, sel unchanged.
- Assert i_rst mid-frame with sel=2 in MANUAL mode -> outputs go to their reset values immediately, asynchronously, without waiting for a clock edge.
